// File: rtl/penc_serializer.sv
// rtl/penc_serializer.sv - priority-order serializer: one index beat per set bit of an accepted vector
// Optional feature: define PENC_COUNT_EN to add the cnt (popcount of accepted vector) output.
module penc_serializer #(
    parameter int N = 16,
    localparam int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  req,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] a,
    output logic          y,
    output logic          y_ex,
    output logic          last
`ifdef PENC_COUNT_EN
    ,
    output logic [AW:0]   cnt
`endif
);

    typedef enum logic {IDLE, EMIT} state_t;

    localparam logic [N-1:0] ONE = N'(1);

    state_t        state_q, state_d;
    logic [N-1:0]  pend_q, pend_d;
    logic [N-1:0]  pend_clr;
    logic [AW-1:0] low_idx;
    logic          emit, is_last, beat, accept;

    always_comb begin
        low_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pend_q[i]) low_idx = AW'(i);
        end
    end

    // Clearing the lowest set bit doubles as the "one bit left" test.
    assign pend_clr = pend_q & (pend_q - ONE);

    always_comb begin
        emit      = (state_q == EMIT);
        is_last   = (pend_clr == '0);
        out_valid = emit;
        a         = emit ? low_idx : '0;
        y         = emit & (pend_q == '0);
        y_ex      = emit & (pend_q != '0);
        last      = emit & is_last;
        beat      = emit & out_ready;
        in_ready  = en & ~rst & (~emit | (beat & is_last));
        accept    = in_valid & in_ready;
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        if (beat) begin
            pend_d = pend_clr;
            if (is_last) state_d = IDLE;
        end
        if (accept) begin
            pend_d  = req;
            state_d = EMIT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

`ifdef PENC_COUNT_EN
    logic [AW:0] cnt_q, cnt_d;

    function automatic logic [AW:0] popcount(input logic [N-1:0] v);
        logic [AW:0] s;
        s = '0;
        for (int i = 0; i < N; i++) s = s + (AW + 1)'(v[i]);
        return s;
    endfunction

    always_comb begin
        cnt_d = cnt_q;
        if (beat && is_last) cnt_d = '0;
        if (accept) cnt_d = popcount(req);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
`endif

endmodule

// File: tb/tb_penc_serializer.sv
// tb/tb_penc_serializer.sv - directed and random checks of penc_serializer against a beat-queue model
module tb_penc_serializer;

    localparam int N  = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst, en, in_valid, in_ready, out_valid, out_ready;
    logic [N-1:0]  req;
    logic [AW-1:0] a;
    logic          y, y_ex, last;
`ifdef PENC_COUNT_EN
    logic [AW:0]   cnt;
`endif

    always #5 clk = ~clk;

    penc_serializer #(.N(N)) dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .req(req), .out_valid(out_valid), .out_ready(out_ready),
        .a(a), .y(y), .y_ex(y_ex), .last(last)
`ifdef PENC_COUNT_EN
        , .cnt(cnt)
`endif
    );

    typedef struct {
        int idx;
        bit empty;
        bit fin;
    } beat_t;

    beat_t q[$];
    int    obs[$];
    int    m_cnt = 0;
    int    n_vec = 0;
    int    n_err = 0;
    bit    chk_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected beats for a vector: ascending set-bit indices, or one empty beat.
    task automatic load(input logic [N-1:0] v);
        beat_t b;
        q.delete();
        m_cnt = 0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                b.idx = i; b.empty = 1'b0; b.fin = 1'b0;
                q.push_back(b);
                m_cnt++;
            end
        end
        if (q.size() == 0) begin
            b.idx = 0; b.empty = 1'b1; b.fin = 1'b1;
            q.push_back(b);
        end else begin
            q[q.size() - 1].fin = 1'b1;
        end
    endtask

    task automatic step(input bit r, input bit e, input bit iv, input logic [N-1:0] rq, input bit ordy);
        bit mv, mr;
        @(negedge clk);
        rst = r; en = e; in_valid = iv; req = rq; out_ready = ordy;
        #1;
        mv = (q.size() != 0);
        mr = e && !r && (q.size() == 0 || (ordy && q.size() == 1));
        check("in_ready", 32'(in_ready), 32'(mr));
        if (chk_en) begin
            check("out_valid", 32'(out_valid), 32'(mv));
            if (mv) begin
                check("a", 32'(a), 32'(q[0].idx));
                check("y", 32'(y), 32'(q[0].empty));
                check("y_ex", 32'(y_ex), 32'(!q[0].empty));
                check("last", 32'(last), 32'(q[0].fin));
            end else begin
                check("a_idle", 32'(a), 32'd0);
                check("y_idle", 32'(y), 32'd0);
                check("y_ex_idle", 32'(y_ex), 32'd0);
                check("last_idle", 32'(last), 32'd0);
            end
`ifdef PENC_COUNT_EN
            check("cnt", 32'(cnt), 32'(m_cnt));
`endif
            if (out_valid === 1'b1 && ordy) obs.push_back(int'(a));
        end
        @(posedge clk);
        if (r) begin
            q.delete();
            m_cnt = 0;
        end else begin
            if (mv && ordy) begin
                void'(q.pop_front());
                if (q.size() == 0) m_cnt = 0;
            end
            if (iv && mr) load(rq);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, '0, 1'b1);
    endtask

    logic [N-1:0] rv;

    initial begin
        rst = 1'b1; en = 1'b1; in_valid = 1'b0; req = '0; out_ready = 1'b0;

        step(1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b1);
        chk_en = 1'b1;
        step(1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b1);
        idle(1);

        obs.delete();
        step(1'b0, 1'b1, 1'b1, 16'h8421, 1'b1);
        idle(5);
        check("ser_beats", 32'(obs.size()), 32'd4);
        if (obs.size() == 4) begin
            check("ser_a0", 32'(obs[0]), 32'd0);
            check("ser_a1", 32'(obs[1]), 32'd5);
            check("ser_a2", 32'(obs[2]), 32'd10);
            check("ser_a3", 32'(obs[3]), 32'd15);
        end

        obs.delete();
        step(1'b0, 1'b1, 1'b1, 16'h0000, 1'b1);
        idle(2);
        check("empty_beats", 32'(obs.size()), 32'd1);

        step(1'b0, 1'b1, 1'b1, 16'h0003, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        idle(3);

        step(1'b0, 1'b1, 1'b1, 16'h8421, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, '0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 16'h8000, 1'b1);
        step(1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b1);
        obs.delete();
        idle(17);
        check("full_beats", 32'(obs.size()), 32'd16);
        if (obs.size() == 16) begin
            for (int i = 0; i < 16; i++) check("full_a", 32'(obs[i]), 32'(i));
        end

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b1);
        obs.delete();
        step(1'b0, 1'b1, 1'b1, 16'h00F0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b1);
        step(1'b0, 1'b1, 1'b0, '0, 1'b1);
        idle(1);
        check("en_drain_beats", 32'(obs.size()), 32'd4);

        step(1'b0, 1'b1, 1'b1, 16'h00F0, 1'b1);
        step(1'b0, 1'b1, 1'b0, '0, 1'b1);
        step(1'b0, 1'b1, 1'b0, '0, 1'b1);
        step(1'b1, 1'b1, 1'b0, '0, 1'b1);
        idle(2);

        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0:       rv = '0;
                1:       rv = '1;
                2:       rv = N'(1) << $urandom_range(0, N - 1);
                default: rv = N'($urandom);
            endcase
            step($urandom_range(0, 63) == 0, $urandom_range(0, 9) < 8,
                 $urandom_range(0, 1) == 1, rv, $urandom_range(0, 9) < 7);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
